ifetch_queue: RTL and testbench

Parametrised in-order fetch queue placed between the IF stage and ID. It issues instruction requests with a valid/ready handshake and reserves a slot for each one. It accepts SRAM-like responses in order and presents filled entries to ID through a valid/ready handshake. It supports pipeline flush (exception/ertn/branch) with any number of requests in flight, discarding their late responses.

---
 rtl/ifetch_queue_if.sv | 47 ++++
 rtl/ifetch_queue.sv | 153 +++++++++++++++
 tb/tb_ifetch_queue.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue_if
// Purpose  : Bundles the fetch-queue handshakes: request issue (IF side),
//            in-order instruction response, and head presentation to ID.
// Modports : master - environment side (drives requests/responses/out_ready)
//            slave  - queue side (drives req_ready and the out_* signals)
// Signals  : flush, req_valid/req_ready/req_pc/req_exc,
//            resp_valid/resp_inst/resp_err,
//            out_valid/out_ready/out_pc/out_inst/out_exc, count
// Revision : 1.0 - initial release
// ============================================================================
interface ifetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              req_exc;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_inst;
  logic              resp_err;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              out_exc;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, req_valid, req_pc, req_exc,
    output resp_valid, resp_inst, resp_err, out_ready,
    input  req_ready, out_valid, out_pc, out_inst, out_exc, count
  );

  modport slave (
    input  flush, req_valid, req_pc, req_exc,
    input  resp_valid, resp_inst, resp_err, out_ready,
    output req_ready, out_valid, out_pc, out_inst, out_exc, count
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Purpose  : In-order instruction fetch queue between IF and ID. Each issued
//            request reserves a slot; in-order responses fill slots; filled
//            head entries are handed to ID. A flush abandons all reserved
//            slots and drops the responses still owed for them.
// Ports    : clk  - clock (rising edge)
//            rst  - synchronous active-high reset
//            bus  - ifetch_queue_if.slave (request, response, output, count)
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  ifetch_queue_if.slave  bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;                         // pointer with wrap bit
  localparam int DW = $clog2(MAX_OUT) + 1;            // discard counter
  localparam int OW = ((PW > DW) ? PW : DW) + 1;      // outstanding sum

  // Pointers: head <= fill <= tail (modulo wrap)
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_fill;
  logic [PW-1:0]     r_tail;
  logic [DW-1:0]     r_disc_cnt;
  logic              r_spurious;

  // Entry storage
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [DATA_W-1:0] r_inst [DEPTH];
  logic [DEPTH-1:0]  r_exc;
  logic [DEPTH-1:0]  r_filled;

  logic [PW-1:0]     w_reserved;
  logic [PW-1:0]     w_inflight;
  logic [OW-1:0]     w_outstanding;
  logic [OW-1:0]     w_disc_flush;
  logic [IW-1:0]     w_head_idx;
  logic [IW-1:0]     w_fill_idx;
  logic [IW-1:0]     w_tail_idx;
  logic              w_req_ready;
  logic              w_req_fire;
  logic              w_resp_drop;
  logic              w_resp_take;
  logic              w_resp_spur;
  logic              w_out_valid;
  logic              w_deq_fire;

  assign w_reserved    = r_tail - r_head;
  assign w_inflight    = r_tail - r_fill;
  assign w_outstanding = OW'(w_inflight) + OW'(r_disc_cnt);

  assign w_head_idx = r_head[IW-1:0];
  assign w_fill_idx = r_fill[IW-1:0];
  assign w_tail_idx = r_tail[IW-1:0];

  // Issue gating uses registered state only, so a dequeue in the same cycle
  // never frees a slot for an immediate request.
  assign w_req_ready = !rst && !bus.flush
                       && (w_reserved < PW'(DEPTH))
                       && (w_outstanding < OW'(MAX_OUT));
  assign w_req_fire  = bus.req_valid && w_req_ready;

  // Responses are consumed first by pending discards, then by in-flight slots.
  assign w_resp_drop = bus.resp_valid && (r_disc_cnt != '0);
  assign w_resp_take = bus.resp_valid && (r_disc_cnt == '0) && (w_inflight != '0);
  assign w_resp_spur = bus.resp_valid && (r_disc_cnt == '0) && (w_inflight == '0);

  // On flush, everything still owed after this cycle must be discarded:
  // old discards + in-flight, minus a response consumed this very cycle.
  assign w_disc_flush = (w_resp_drop || w_resp_take) ? (w_outstanding - OW'(1))
                                                      : w_outstanding;

  assign w_out_valid = !rst && !bus.flush && (r_head != r_fill);
  assign w_deq_fire  = w_out_valid && bus.out_ready;

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_fill     <= '0;
      r_tail     <= '0;
      r_disc_cnt <= '0;
      r_filled   <= '0;
      r_spurious <= 1'b0;
    end else begin
      if (w_resp_spur) begin
        r_spurious <= 1'b1;
      end
      if (bus.flush) begin
        r_head     <= r_tail;
        r_fill     <= r_tail;
        r_disc_cnt <= DW'(w_disc_flush);
      end else begin
        if (w_req_fire) begin
          r_filled[w_tail_idx] <= 1'b0;
          r_tail               <= r_tail + PW'(1);
        end
        if (w_resp_drop) begin
          r_disc_cnt <= r_disc_cnt - DW'(1);
        end
        if (w_resp_take) begin
          r_filled[w_fill_idx] <= 1'b1;
          r_fill               <= r_fill + PW'(1);
        end
        if (w_deq_fire) begin
          r_head <= r_head + PW'(1);
        end
      end
    end
  end

  // Entry payload; contents are only meaningful once the slot is filled.
  // Request and response never target the same slot in one cycle because a
  // response needs fill != tail and a request needs a free slot at tail.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush) begin
      if (w_req_fire) begin
        r_pc[w_tail_idx]  <= bus.req_pc;
        r_exc[w_tail_idx] <= bus.req_exc;
      end
      if (w_resp_take) begin
        r_inst[w_fill_idx] <= bus.resp_inst;
        r_exc[w_fill_idx]  <= r_exc[w_fill_idx] | bus.resp_err;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = r_pc[w_head_idx];
  assign bus.out_inst  = r_inst[w_head_idx];
  assign bus.out_exc   = r_exc[w_head_idx];
  assign bus.count     = rst ? '0 : w_reserved;

  // Internal consistency checks
  a_no_spurious_resp: assert property (@(posedge clk) disable iff (rst)
    !r_spurious);
  a_head_filled: assert property (@(posedge clk) disable iff (rst)
    (r_head != r_fill) |-> r_filled[w_head_idx]);
  a_reserved_bound: assert property (@(posedge clk) disable iff (rst)
    w_reserved <= PW'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_queue
// Purpose  : Self-checking bench for ifetch_queue. A streaming vector table
//            plus directed sequences for backpressure/wrap, flush with
//            in-flight requests, flush coincident with a response, exception
//            tagging, and outstanding-limit behaviour with MAX_OUT=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus ();
  ifetch_queue_if #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) bus2 ();

  ifetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ifetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .MAX_OUT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic        respv;
    logic [31:0] inst;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.flush = 0;  bus.req_valid = 0;  bus.req_pc = '0;  bus.req_exc = 0;
    bus.resp_valid = 0; bus.resp_inst = '0; bus.resp_err = 0; bus.out_ready = 0;
    bus2.flush = 0; bus2.req_valid = 0; bus2.req_pc = '0; bus2.req_exc = 0;
    bus2.resp_valid = 0; bus2.resp_inst = '0; bus2.resp_err = 0; bus2.out_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcs  [4];
    logic [31:0] ins  [4];
    logic        xexc [4];
    logic        xerr [4];
    logic        eexc [4];

    // ---------------- reset ----------------
    idle_all();
    rst = 1;
    bus.req_valid  = 1;
    bus2.req_valid = 1;
    tick();
    tick();
    chk("rst_req_ready",  bus.req_ready, 0);
    chk("rst_out_valid",  bus.out_valid, 0);
    chk("rst_count",      bus.count, 0);
    chk("rst2_req_ready", bus2.req_ready, 0);
    rst = 0;
    idle_all();
    #1;
    chk("post_rst_req_ready", bus.req_ready, 1);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_count",     bus.count, 0);

    // ---------------- stream table ----------------
    vecs[0] = '{1'b1, 32'h1c000000, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0};
    vecs[1] = '{1'b1, 32'h1c000004, 1'b1, 32'h02800401, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd1};
    vecs[2] = '{1'b1, 32'h1c000008, 1'b1, 32'h02800402, 1'b1, 1'b1, 1'b1, 32'h1c000000, 32'h02800401, 3'd2};
    vecs[3] = '{1'b1, 32'h1c00000c, 1'b1, 32'h02800403, 1'b1, 1'b1, 1'b1, 32'h1c000004, 32'h02800402, 3'd2};
    vecs[4] = '{1'b0, 32'h0,        1'b1, 32'h02800404, 1'b1, 1'b1, 1'b1, 32'h1c000008, 32'h02800403, 3'd2};
    vecs[5] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h1c00000c, 32'h02800404, 3'd1};
    vecs[6] = '{1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0};
    for (int i = 0; i < 7; i++) begin
      bus.req_valid  = vecs[i].rv;
      bus.req_pc     = vecs[i].pc;
      bus.resp_valid = vecs[i].respv;
      bus.resp_inst  = vecs[i].inst;
      bus.out_ready  = vecs[i].ordy;
      #1;
      chk($sformatf("stream%0d_req_ready", i), bus.req_ready, vecs[i].e_rdy);
      chk($sformatf("stream%0d_out_valid", i), bus.out_valid, vecs[i].e_ov);
      chk($sformatf("stream%0d_count", i),     bus.count, vecs[i].e_cnt);
      if (vecs[i].e_ov) begin
        chk($sformatf("stream%0d_out_pc", i),   bus.out_pc, vecs[i].e_pc);
        chk($sformatf("stream%0d_out_inst", i), bus.out_inst, vecs[i].e_inst);
        chk($sformatf("stream%0d_out_exc", i),  bus.out_exc, 0);
      end
      tick();
    end
    idle_all();

    // ---------------- full / backpressure, 3 laps ----------------
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 4; i++) begin
        pcs[i] = 32'h1c001000 + 32'(lap * 256) + 32'(i * 4);
        ins[i] = 32'ha0000000 + 32'(lap * 16) + 32'(i);
      end
      for (int i = 0; i < 4; i++) begin
        bus.req_valid = 1; bus.req_pc = pcs[i];
        #1;
        chk($sformatf("lap%0d_issue%0d_ready", lap, i), bus.req_ready, 1);
        tick();
      end
      bus.req_valid = 0;
      for (int i = 0; i < 4; i++) begin
        bus.resp_valid = 1; bus.resp_inst = ins[i];
        tick();
      end
      bus.resp_valid = 0;
      bus.req_valid  = 1; bus.req_pc = 32'hffff0000;
      bus.out_ready  = 1;
      #1;
      chk($sformatf("lap%0d_full_ready", lap), bus.req_ready, 0);
      chk($sformatf("lap%0d_full_count", lap), bus.count, 4);
      chk($sformatf("lap%0d_head_valid", lap), bus.out_valid, 1);
      chk($sformatf("lap%0d_head_pc", lap),    bus.out_pc, pcs[0]);
      chk($sformatf("lap%0d_head_inst", lap),  bus.out_inst, ins[0]);
      tick();
      bus.req_valid = 0; bus.out_ready = 0;
      #1;
      chk($sformatf("lap%0d_ready_after_deq", lap), bus.req_ready, 1);
      chk($sformatf("lap%0d_count_after_deq", lap), bus.count, 3);
      for (int i = 1; i < 4; i++) begin
        bus.out_ready = 1;
        #1;
        chk($sformatf("lap%0d_drain%0d_valid", lap, i), bus.out_valid, 1);
        chk($sformatf("lap%0d_drain%0d_pc", lap, i),    bus.out_pc, pcs[i]);
        chk($sformatf("lap%0d_drain%0d_inst", lap, i),  bus.out_inst, ins[i]);
        tick();
      end
      bus.out_ready = 0;
      #1;
      chk($sformatf("lap%0d_empty_valid", lap), bus.out_valid, 0);
      chk($sformatf("lap%0d_empty_count", lap), bus.count, 0);
    end
    idle_all();

    // ---------------- flush with in-flight requests ----------------
    bus.req_valid = 1; bus.req_pc = 32'h1c002000; tick();
    bus.req_pc = 32'h1c002004; tick();
    bus.req_pc = 32'h1c002008; bus.resp_valid = 1; bus.resp_inst = 32'h11111111; tick();
    bus.req_valid = 0; bus.resp_valid = 0; bus.flush = 1;
    #1;
    chk("fl_cycle_out_valid", bus.out_valid, 0);
    chk("fl_cycle_req_ready", bus.req_ready, 0);
    tick();
    bus.flush = 0;
    #1;
    chk("fl_next_out_valid", bus.out_valid, 0);
    chk("fl_next_count",     bus.count, 0);
    chk("fl_discard_cnt",    dut.r_disc_cnt, 2);
    chk("fl_next_req_ready", bus.req_ready, 1);
    bus.req_valid = 1; bus.req_pc = 32'h1c008000;
    bus.resp_valid = 1; bus.resp_inst = 32'hdead0001;
    tick();
    bus.req_valid = 0; bus.resp_inst = 32'hdead0002;
    #1;
    chk("fl_drop1_out_valid", bus.out_valid, 0);
    tick();
    bus.resp_inst = 32'h03400000;
    #1;
    chk("fl_drop2_out_valid", bus.out_valid, 0);
    chk("fl_discard_done",    dut.r_disc_cnt, 0);
    tick();
    bus.resp_valid = 0; bus.out_ready = 1;
    #1;
    chk("fl_new_valid", bus.out_valid, 1);
    chk("fl_new_pc",    bus.out_pc, 32'h1c008000);
    chk("fl_new_inst",  bus.out_inst, 32'h03400000);
    chk("fl_new_exc",   bus.out_exc, 0);
    tick();
    bus.out_ready = 0;
    #1;
    chk("fl_final_count", bus.count, 0);
    idle_all();

    // ---------------- flush coincident with a response ----------------
    bus.req_valid = 1; bus.req_pc = 32'h1c00a000; tick();
    bus.req_pc = 32'h1c00a004; tick();
    bus.req_valid = 0; bus.flush = 1;
    bus.resp_valid = 1; bus.resp_inst = 32'hbad00001;
    tick();
    bus.flush = 0; bus.resp_valid = 0;
    #1;
    chk("co_discard_cnt", dut.r_disc_cnt, 1);
    chk("co_out_valid",   bus.out_valid, 0);
    chk("co_count",       bus.count, 0);
    bus.req_valid = 1; bus.req_pc = 32'h1c00b000;
    bus.resp_valid = 1; bus.resp_inst = 32'hbad00002;
    tick();
    bus.req_valid = 0; bus.resp_inst = 32'h0280beef;
    #1;
    chk("co_drop_out_valid", bus.out_valid, 0);
    chk("co_discard_done",   dut.r_disc_cnt, 0);
    tick();
    bus.resp_valid = 0; bus.out_ready = 1;
    #1;
    chk("co_deliver_valid", bus.out_valid, 1);
    chk("co_deliver_pc",    bus.out_pc, 32'h1c00b000);
    chk("co_deliver_inst",  bus.out_inst, 32'h0280beef);
    tick();
    idle_all();

    // ---------------- exception tagging ----------------
    pcs[0] = 32'h1c000000; pcs[1] = 32'h1c000002; pcs[2] = 32'h1c000004; pcs[3] = 32'h1c000008;
    xexc[0] = 0; xexc[1] = 1; xexc[2] = 0; xexc[3] = 0;
    xerr[0] = 0; xerr[1] = 0; xerr[2] = 1; xerr[3] = 0;
    eexc[0] = 0; eexc[1] = 1; eexc[2] = 1; eexc[3] = 0;
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = (k < 4);
      bus.req_pc    = (k < 4) ? pcs[k] : 32'h0;
      bus.req_exc   = (k < 4) ? xexc[k] : 1'b0;
      bus.resp_valid = (k >= 1);
      bus.resp_inst  = 32'h00001000 + 32'(k);
      bus.resp_err   = (k >= 1) ? xerr[k-1] : 1'b0;
      tick();
    end
    idle_all();
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = 1;
      #1;
      chk($sformatf("exc%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("exc%0d_pc", i),    bus.out_pc, pcs[i]);
      chk($sformatf("exc%0d_flag", i),  bus.out_exc, eexc[i]);
      tick();
    end
    idle_all();

    // ---------------- MAX_OUT=2 outstanding limit ----------------
    bus2.req_valid = 1; bus2.req_pc = 32'h1c00c000;
    #1;
    chk("mo_issue0_ready", bus2.req_ready, 1);
    tick();
    bus2.req_pc = 32'h1c00c004;
    #1;
    chk("mo_issue1_ready", bus2.req_ready, 1);
    tick();
    bus2.req_pc = 32'h1c00c008;
    #1;
    chk("mo_limit_ready", bus2.req_ready, 0);
    chk("mo_limit_count", bus2.count, 2);
    tick();
    bus2.req_valid = 0; bus2.flush = 1;
    tick();
    bus2.flush = 0; bus2.req_valid = 1; bus2.resp_valid = 1; bus2.resp_inst = 32'h0;
    #1;
    chk("mo_postflush_ready", bus2.req_ready, 0);
    chk("mo_postflush_count", bus2.count, 0);
    chk("mo_postflush_disc",  dut2.r_disc_cnt, 2);
    bus2.req_valid = 0;
    tick();
    bus2.resp_valid = 0;
    #1;
    chk("mo_after_drop_ready", bus2.req_ready, 1);
    tick();
    idle_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
